// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath and its stream reader.
package conv_pkg;

  localparam int W       = 64;
  localparam int MAX_LEN = 256;

  // One vector element: an IEEE-754 double carried as a raw bit pattern.
  typedef logic [W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } reader_state_t;

  // Number of valid outputs of a 'valid' convolution (8-bit wrap-around).
  function automatic logic [7:0] calc_cnt(input logic [7:0] len1, input logic [7:0] len2);
    return len1 - len2 + 8'd1;
  endfunction

  // The kernel must be non-empty and no longer than the matrix.
  function automatic logic lens_legal(input logic [7:0] len1, input logic [7:0] len2);
    return (len2 != 8'd0) && (len2 <= len1);
  endfunction

endpackage

// File: rtl/conv_stream_reader_if.sv
// Element stream from the reader to its consumer.
//
// Handshake: an element moves on every rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_valid, out_data,
// out_index and out_last hold unchanged until that transfer happens.
// out_valid never waits on out_ready.
interface conv_stream_reader_if #(
  parameter int DW = conv_pkg::W
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_index;
  logic          out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv_stream_reader.sv
// Captures a convolved vector on start and streams its cnt = len1-len2+1
// leading elements, one per accepted handshake.
module conv_stream_reader
  import conv_pkg::*;
#(
  parameter int N       = 16,
  parameter int M       = 4,
  parameter int W       = conv_pkg::W,
  parameter int MAX_LEN = conv_pkg::MAX_LEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  len1,
  input  logic [7:0]                  len2,
  input  logic [MAX_LEN-1:0][W-1:0]   y,
  conv_stream_reader_if.master        stream,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output reader_state_t               state_dbg,
  output logic [7:0]                  nominal_cnt
);

  reader_state_t state_q, state_d;

  logic [W-1:0] buf_q [MAX_LEN];
  logic [7:0]   cnt_q;
  logic [7:0]   index_q;
  logic [W-1:0] data_q;
  logic         valid_q;
  logic         last_q;
  logic         err_q;
  logic         accept;
  logic         reject;
  logic         xfer;

  assign xfer = valid_q && stream.out_ready;

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (lens_legal(len1, len2)) begin
            accept  = 1'b1;
            state_d = LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      LOAD:    state_d = STREAM;
      STREAM:  if (xfer && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Snapshot of y; contents are meaningless until the first accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= y[i];
    end
  end

  // Output register: preloads element 0 in LOAD and advances on each transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      index_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) cnt_q <= calc_cnt(len1, len2);
      case (state_q)
        LOAD: begin
          valid_q <= 1'b1;
          index_q <= 8'd0;
          data_q  <= buf_q[0];
          last_q  <= (cnt_q == 8'd1);
        end
        STREAM: begin
          if (xfer) begin
            if (last_q) begin
              valid_q <= 1'b0;
              index_q <= 8'd0;
              data_q  <= '0;
              last_q  <= 1'b0;
            end else begin
              index_q <= index_q + 8'd1;
              data_q  <= buf_q[index_q + 8'd1];
              last_q  <= ((index_q + 8'd1) == (cnt_q - 8'd1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign stream.out_index = index_q;
  assign stream.out_last  = last_q;

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign state_dbg   = state_q;
  assign nominal_cnt = 8'(N - M + 1);

endmodule

// File: tb/tb_conv_stream_reader.sv
// Bench for conv_stream_reader: scoreboarded frames under several ready
// patterns, illegal lengths, snapshot isolation and mid-frame reset.
module tb_conv_stream_reader;
  import conv_pkg::*;

  localparam int TW = 64;
  localparam int TL = 256;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic [7:0]              len1;
  logic [7:0]              len2;
  logic [TL-1:0][TW-1:0]   y_v;
  logic                    busy;
  logic                    done;
  logic                    err;
  reader_state_t           state_dbg;
  logic [7:0]              nominal_cnt;

  conv_stream_reader_if #(.DW(TW)) bus ();

  conv_stream_reader #(.N(16), .M(4), .W(TW), .MAX_LEN(TL)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len1        (len1),
    .len2        (len2),
    .y           (y_v),
    .stream      (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .state_dbg   (state_dbg),
    .nominal_cnt (nominal_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;
  int n_xfer      = 0;
  int n_done      = 0;
  int rdy_mode    = 0;

  // Expected element: {last, index, data}
  logic [TW+8:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_y(input int kind);
    for (int i = 0; i < TL; i++) begin
      if (kind == 0 && i < 16) y_v[i] = $realtobits(0.1 * (i + 1));
      else                     y_v[i] = {$urandom, $urandom};
    end
  endtask

  task automatic push_frame(input logic [7:0] l1, input logic [7:0] l2);
    int cnt;
    cnt = int'(l1) - int'(l2) + 1;
    for (int i = 0; i < cnt; i++) exp_q.push_back({(i == cnt - 1), 8'(i), y_v[i]});
  endtask

  // Call at posedge+1 with the DUT idle; start is raised immediately.
  task automatic start_frame(input logic [7:0] l1, input logic [7:0] l2);
    start = 1'b1;
    len1  = l1;
    len2  = l2;
    push_frame(l1, l2);
    @(posedge clk); #1;
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_valid", bus.out_valid, 0);
    check("load_state", state_dbg, LOAD);
    @(posedge clk); #1;
    check("first_valid", bus.out_valid, 1);
    check("first_index", bus.out_index, 0);
  endtask

  task automatic illegal_start(input logic [7:0] l1, input logic [7:0] l2);
    start = 1'b1;
    len1  = l1;
    len2  = l2;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("err_cleared", err, 0);
    check("err_still_idle", busy, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_timeout_busy", busy, 0);
  endtask

  // Ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic          stall_prev = 1'b0;
  logic          exp_done   = 1'b0;
  logic [TW+9:0] held;

  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {bus.out_valid, bus.out_last, bus.out_index, bus.out_data}, held);
      if (done || exp_done) check("done_pulse", done, exp_done);
      if (done) n_done++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("elem_unexpected", exp_q.size(), 1);
        else check("elem", {bus.out_last, bus.out_index, bus.out_data}, exp_q.pop_front());
        n_xfer++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.out_valid, bus.out_last, bus.out_index, bus.out_data};
      exp_done   = bus.out_valid && bus.out_ready && bus.out_last;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int k;
    reset = 1'b0;
    start = 1'b0;
    len1  = 8'd0;
    len2  = 8'd0;
    set_y(0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_index", bus.out_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, IDLE);
    check("nominal_cnt", nominal_cnt, 13);

    // Frame, always ready; start on the first edge after release
    reset    = 1'b1;
    rdy_mode = 0;
    start_frame(8'd16, 8'd4);
    wait_idle(200);
    check("frame_xfers", n_xfer, 13);
    check("frame_done", n_done, 1);

    // Same frame with toggling ready, started the cycle after done
    rdy_mode = 1;
    start_frame(8'd16, 8'd4);
    wait_idle(200);
    check("bp_xfers", n_xfer, 26);
    check("bp_done", n_done, 2);

    // Random data, random ready, different lengths
    rdy_mode = 2;
    set_y(1);
    start_frame(8'd20, 8'd3);
    wait_idle(400);
    check("rand_xfers", n_xfer, 44);
    check("rand_done", n_done, 3);

    // Illegal lengths
    rdy_mode = 1;
    illegal_start(8'd4, 8'd5);
    illegal_start(8'd4, 8'd0);
    illegal_start(8'd0, 8'd0);
    check("illegal_no_xfer", n_xfer, 44);
    check("illegal_queue", exp_q.size(), 0);

    // Snapshot isolation and start-while-busy
    rdy_mode = 0;
    set_y(0);
    start_frame(8'd16, 8'd4);
    repeat (3) begin
      @(posedge clk); #1;
    end
    set_y(1);
    start = 1'b1;
    len1  = 8'd10;
    len2  = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_err", err, 0);
    check("busy_start_state", state_dbg, STREAM);
    wait_idle(200);
    check("snap_xfers", n_xfer, 57);
    check("snap_done", n_done, 4);

    // Reset after index 5 has been transferred
    base = n_xfer;
    start_frame(8'd16, 8'd4);
    k = 0;
    while (n_xfer < base + 6 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("pre_reset_xfers", n_xfer, base + 6);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_last", bus.out_last, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_index", bus.out_index, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    set_y(1);
    start_frame(8'd8, 8'd8);
    check("single_last", bus.out_last, 1);
    wait_idle(50);
    check("single_xfers", n_xfer, base + 7);
    check("single_done", n_done, 5);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
